// File: rtl/cascaded_counter_array.sv
// N cascaded W-bit up/down counter stages forming one W*N-bit counter; all stages step on the same edge.
// Optional registered match comparator is enabled by defining CASCADED_COUNTER_MATCH_EN.
module cascaded_counter_array #(
   parameter int STAGE_WIDTH = 16,
   parameter int NUM_STAGES  = 4
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                enable,
   input  logic                                up_down,
   input  logic                                oneshot,
   input  logic                                clear,
   input  logic                                load,
   input  logic [STAGE_WIDTH*NUM_STAGES-1:0]   load_value,
`ifdef CASCADED_COUNTER_MATCH_EN
   input  logic [STAGE_WIDTH*NUM_STAGES-1:0]   match_value,
   output logic                                match,
`endif
   output logic [STAGE_WIDTH*NUM_STAGES-1:0]   count,
   output logic [NUM_STAGES-1:0]               stage_tc,
   output logic                                wrap,
   output logic                                done
);

   localparam int W  = STAGE_WIDTH;
   localparam int CW = STAGE_WIDTH * NUM_STAGES;
   localparam logic [W-1:0] STAGE_ONE = W'(1);

   typedef enum logic {S_RUN, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d, step_count;
   logic            wrap_q, wrap_d;
   logic            step_en, carry, chain_tc, halt_hit;
   logic [W-1:0]    stage_v;

   // Carry ripples combinationally so the whole chain advances in a single edge.
   always_comb begin
      step_en    = enable && (state_q == S_RUN);
      carry      = step_en;
      stage_v    = '0;
      step_count = count_q;
      stage_tc   = '0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         stage_v     = count_q[i*W +: W];
         stage_tc[i] = carry && (up_down ? (&stage_v) : ~(|stage_v));
         if (carry) begin
            step_count[i*W +: W] = up_down ? (stage_v + STAGE_ONE) : (stage_v - STAGE_ONE);
         end
         carry = stage_tc[i];
      end
      chain_tc = stage_tc[NUM_STAGES-1];
   end

   always_comb begin
      halt_hit = chain_tc && oneshot;
      count_d  = step_count;
      state_d  = state_q;
      wrap_d   = 1'b0;
      if (clear) begin
         count_d = '0;
         state_d = S_RUN;
      end else if (load) begin
         count_d = load_value;
         state_d = S_RUN;
      end else if (halt_hit) begin
         // One-shot terminal: freeze at the terminal value instead of rolling over.
         count_d = count_q;
         state_d = S_DONE;
      end else begin
         wrap_d = chain_tc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
         state_q <= S_RUN;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         state_q <= state_d;
         wrap_q  <= wrap_d;
      end
   end

`ifdef CASCADED_COUNTER_MATCH_EN
   logic match_q, match_d;

   // Only a load or an actual step can raise match; clear never does.
   always_comb begin
      match_d = !clear && (load || (step_en && !halt_hit)) && (count_d == match_value);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         match_q <= 1'b0;
      end else begin
         match_q <= match_d;
      end
   end

   assign match = match_q;
`endif

   assign count = count_q;
   assign wrap  = wrap_q;
   assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_cascaded_counter_array.sv
// Bench for cascaded_counter_array at W=4, N=3: directed plan steps then random traffic vs. an integer model.
module tb_cascaded_counter_array;

   localparam int W   = 4;
   localparam int N   = 3;
   localparam int MAX = (1 << (W*N)) - 1;

   logic            clk = 1'b0;
   logic            reset, enable, up_down, oneshot, clear, load;
   logic [W*N-1:0]  load_value;
   logic [W*N-1:0]  count;
   logic [N-1:0]    stage_tc;
   logic            wrap, done;

   int n_asserts = 0;
   int n_fail    = 0;

   // Reference model: chain value as a plain integer plus the two registered flags.
   int m_cnt  = 0;
   bit m_wrap = 1'b0;
   bit m_done = 1'b0;

   cascaded_counter_array #(.STAGE_WIDTH(W), .NUM_STAGES(N)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .up_down    (up_down),
      .oneshot    (oneshot),
      .clear      (clear),
      .load       (load),
      .load_value (load_value),
      .count      (count),
      .stage_tc   (stage_tc),
      .wrap       (wrap),
      .done       (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Stage i is terminal when the low (i+1)*W bits of the chain sit at their extreme and the chain is enabled.
   function automatic logic [N-1:0] model_tc();
      logic [N-1:0] tc;
      int           md, low;
      tc = '0;
      for (int i = 0; i < N; i++) begin
         md  = 1 << ((i+1)*W);
         low = m_cnt % md;
         tc[i] = enable && !m_done && (up_down ? (low == md - 1) : (low == 0));
      end
      return tc;
   endfunction

   task automatic drive(input bit rst, input bit en, input bit ud, input bit os,
                        input bit clr, input bit ld, input logic [W*N-1:0] lv);
      reset = rst; enable = en; up_down = ud; oneshot = os;
      clear = clr; load = ld; load_value = lv;
   endtask

   task automatic check_model();
      #1;
      chk("count",    32'(count),    32'(m_cnt));
      chk("wrap",     32'(wrap),     32'(m_wrap));
      chk("done",     32'(done),     32'(m_done));
      chk("stage_tc", 32'(stage_tc), 32'(model_tc()));
   endtask

   task automatic tick();
      @(posedge clk);
      if (reset || clear) begin
         m_cnt = 0; m_wrap = 0; m_done = 0;
      end else if (load) begin
         m_cnt = int'(load_value); m_wrap = 0; m_done = 0;
      end else if (enable && !m_done) begin
         m_wrap = 0;
         if (up_down ? (m_cnt == MAX) : (m_cnt == 0)) begin
            if (oneshot) m_done = 1;
            else begin
               m_cnt  = up_down ? 0 : MAX;
               m_wrap = 1;
            end
         end else begin
            m_cnt = up_down ? m_cnt + 1 : m_cnt - 1;
         end
      end else begin
         m_wrap = 0;
      end
      @(negedge clk);
   endtask

   task automatic cyc(input bit rst, input bit en, input bit ud, input bit os,
                      input bit clr, input bit ld, input logic [W*N-1:0] lv);
      drive(rst, en, ud, os, clr, ld, lv);
      check_model();
      tick();
   endtask

   initial begin
      logic [W*N-1:0] lv;
      bit             ud, os;
      int             r;

      // Reset, then 20 up counts.
      drive(1, 0, 1, 0, 0, 0, '0);
      @(negedge clk);
      cyc(1, 0, 1, 0, 0, 0, '0);
      cyc(1, 0, 1, 0, 0, 0, '0);
      chk("rst_count", 32'(count), 32'h0);
      chk("rst_wrap",  32'(wrap),  32'h0);
      chk("rst_done",  32'(done),  32'h0);
      for (int i = 0; i < 20; i++) cyc(0, 1, 1, 0, 0, 0, '0);
      chk("up20_count", 32'(count), 32'h014);

      // Free-run wrap from 0xFFE.
      cyc(0, 0, 1, 0, 0, 1, 12'hFFE);
      chk("ld_ffe", 32'(count), 32'hFFE);
      cyc(0, 1, 1, 0, 0, 0, '0);
      chk("free_fff", 32'(count), 32'hFFF);
      cyc(0, 1, 1, 0, 0, 0, '0);
      chk("free_000", 32'(count), 32'h000);
      chk("free_wrap", 32'(wrap), 32'h1);
      chk("free_done", 32'(done), 32'h0);
      cyc(0, 1, 1, 0, 0, 0, '0);
      chk("wrap_once", 32'(wrap), 32'h0);

      // One-shot halt at 0xFFF, oneshot drop does not release, clear does.
      cyc(0, 0, 1, 1, 0, 1, 12'hFFE);
      cyc(0, 1, 1, 1, 0, 0, '0);
      cyc(0, 1, 1, 1, 0, 0, '0);
      chk("os_hold", 32'(count), 32'hFFF);
      chk("os_done", 32'(done),  32'h1);
      chk("os_nowrap", 32'(wrap), 32'h0);
      cyc(0, 1, 1, 0, 0, 0, '0);
      chk("os_stay_done", 32'(done), 32'h1);
      chk("os_stay_cnt", 32'(count), 32'hFFF);
      cyc(0, 1, 1, 0, 1, 0, '0);
      chk("clr_count", 32'(count), 32'h000);
      chk("clr_done",  32'(done),  32'h0);
      cyc(0, 1, 1, 0, 0, 0, '0);
      chk("resume", 32'(count), 32'h001);

      // Down count through zero.
      cyc(0, 0, 0, 0, 0, 1, 12'h002);
      cyc(0, 1, 0, 0, 0, 0, '0);
      cyc(0, 1, 0, 0, 0, 0, '0);
      chk("dn_000", 32'(count), 32'h000);
      drive(0, 1, 0, 0, 0, 0, '0);
      #1 chk("dn_tc_all", 32'(stage_tc), 32'h7);
      tick();
      chk("dn_fff",  32'(count), 32'hFFF);
      chk("dn_wrap", 32'(wrap),  32'h1);

      // Load wins over a same-edge terminal; reset mid-count.
      cyc(0, 0, 1, 0, 0, 1, 12'hFFF);
      cyc(0, 1, 1, 0, 0, 1, 12'h123);
      chk("ldwin_cnt",  32'(count), 32'h123);
      chk("ldwin_wrap", 32'(wrap),  32'h0);
      chk("ldwin_done", 32'(done),  32'h0);
      cyc(0, 1, 1, 0, 0, 0, '0);
      cyc(1, 1, 1, 0, 0, 0, '0);
      chk("rst_mid", 32'(count), 32'h000);

      // Random traffic, biased toward the chain extremes.
      ud = 1; os = 0;
      for (int i = 0; i < 3000; i++) begin
         r = $urandom_range(0, 63);
         case ($urandom_range(0, 2))
            0:       lv = 12'hFFF - 12'($urandom_range(0, 3));
            1:       lv = 12'($urandom_range(0, 3));
            default: lv = 12'($urandom);
         endcase
         if ($urandom_range(0, 15) == 0) ud = ~ud;
         if ($urandom_range(0, 31) == 0) os = ~os;
         cyc(r == 0, $urandom_range(0, 3) != 0, ud, os, (r == 1) || (r == 2), (r >= 3) && (r <= 6), lv);
      end
      check_model();

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
